// File: rtl/ghost_collision.sv
// Per-frame Pac-Man / ghost collision evaluation with frightened-window tracking
// and the death -> dying hold -> respawn sequence feeding the lives and score logic.
module ghost_collision #(
    parameter int COORD_W       = 10,
    parameter int HIT_DIST      = 8,
    parameter int FRIGHT_FRAMES = 360,
    parameter int DYING_FRAMES  = 120
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic                 halt,
    input  logic [COORD_W-1:0]   pac_x,
    input  logic [COORD_W-1:0]   pac_y,
    input  logic [4*COORD_W-1:0] ghost_x,
    input  logic [4*COORD_W-1:0] ghost_y,
    input  logic                 power_pellet,
    output logic [3:0]           collide,
    output logic [3:0]           ghost_eaten,
    output logic                 frightened,
    output logic                 dying,
    output logic                 respawn
);

    localparam int FR_W = $clog2(FRIGHT_FRAMES + 1);
    localparam int DY_W = $clog2(DYING_FRAMES + 1);

    localparam logic [FR_W-1:0]    FR_LOAD = FR_W'(FRIGHT_FRAMES);
    localparam logic [FR_W-1:0]    FR_ONE  = FR_W'(1);
    localparam logic [DY_W-1:0]    DY_LOAD = DY_W'(DYING_FRAMES);
    localparam logic [DY_W-1:0]    DY_ONE  = DY_W'(1);
    localparam logic [COORD_W:0]   HIT_LIM = (COORD_W + 1)'(HIT_DIST);

    localparam logic [3:0] EV_NONE = 4'b0000;
    localparam logic [3:0] EV_KILL = 4'b0001;
    localparam logic [3:0] EV_EAT  = 4'b0010;

    typedef enum logic [1:0] {
        S_PLAY,
        S_KILL,
        S_DYING,
        S_RESPAWN
    } state_t;

    state_t            state;
    logic [FR_W-1:0]   fright_cnt;
    logic [DY_W-1:0]   dying_cnt;
    logic [3:0]        ovl_p0;
    logic [3:0]        ovl_p1;
    logic              vld_p1;
    logic [3:0]        lethal;
    logic [3:0]        edible;
    logic [3:0]        eat_sel;
    logic              tick_ok;

    // Unsigned distance without wrap: larger minus smaller.
    function automatic logic [COORD_W-1:0] absdiff(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic within_hit(input logic [COORD_W-1:0] a,
                                        input logic [COORD_W-1:0] b);
        return ({1'b0, absdiff(a, b)} < HIT_LIM);
    endfunction

    assign tick_ok    = frame_tick && !halt;
    assign frightened = (fright_cnt != '0);
    assign dying      = (state == S_KILL) || (state == S_DYING);

    // Stage p0: combinational per-ghost overlap against the current positions
    always_comb begin
        ovl_p0 = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            ovl_p0[i] = within_hit(pac_x, ghost_x[i*COORD_W +: COORD_W]) &&
                        within_hit(pac_y, ghost_y[i*COORD_W +: COORD_W]);
        end
    end

    // Stage p1: decide from the registered overlap; lowest-index edible ghost wins
    always_comb begin
        lethal  = frightened ? 4'b0000 : (ovl_p1 & ~ghost_eaten);
        edible  = frightened ? (ovl_p1 & ~ghost_eaten) : 4'b0000;
        eat_sel = 4'b0000;
        for (int i = 3; i >= 0; i--) begin
            if (edible[i]) begin
                eat_sel = 4'b0001 << i;
            end
        end
    end

    // Stage p2: registered event, eaten mask, counters and sequencing state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_PLAY;
            fright_cnt  <= '0;
            dying_cnt   <= '0;
            ovl_p1      <= 4'b0000;
            vld_p1      <= 1'b0;
            collide     <= EV_NONE;
            ghost_eaten <= 4'b0000;
            respawn     <= 1'b0;
        end else begin
            collide <= EV_NONE;
            respawn <= 1'b0;

            if (vld_p1) begin
                vld_p1 <= 1'b0;
            end
            if (tick_ok && state == S_PLAY) begin
                ovl_p1 <= ovl_p0;
                vld_p1 <= 1'b1;
            end

            case (state)
                S_PLAY: begin
                    if (vld_p1) begin
                        if (lethal != 4'b0000) begin
                            state   <= S_KILL;
                            collide <= EV_KILL;
                        end else if (edible != 4'b0000) begin
                            ghost_eaten <= ghost_eaten | eat_sel;
                            collide     <= EV_EAT;
                        end
                    end
                    // Expiry clears the eaten mask after any eat above.
                    if (!halt) begin
                        if (power_pellet) begin
                            fright_cnt <= FR_LOAD;
                        end else if (frame_tick && fright_cnt != '0) begin
                            fright_cnt <= fright_cnt - FR_ONE;
                            if (fright_cnt == FR_ONE) begin
                                ghost_eaten <= 4'b0000;
                            end
                        end
                    end
                end
                S_KILL: begin
                    fright_cnt  <= '0;
                    ghost_eaten <= 4'b0000;
                    dying_cnt   <= DY_LOAD;
                    state       <= S_DYING;
                end
                S_DYING: begin
                    if (tick_ok) begin
                        if (dying_cnt == DY_ONE) begin
                            dying_cnt <= '0;
                            state     <= S_RESPAWN;
                            respawn   <= 1'b1;
                        end else begin
                            dying_cnt <= dying_cnt - DY_ONE;
                        end
                    end
                end
                S_RESPAWN: begin
                    state <= S_PLAY;
                end
                default: begin
                    state <= S_PLAY;
                end
            endcase
        end
    end

endmodule

// File: doc/ghost_collision.md
Name: ghost_collision

Overview:
- Produces the 4-bit `collide` event code consumed by the lives counter and the score logic.
- Once per frame it compares Pac-Man's position against the four ghosts, tracks the power-pellet frightened window and per-ghost eaten state, and sequences death → dying hold → respawn.
- Sits between the sprite/position logic and the lives/score counters.

Parameters:
- COORD_W, 10, width of each x/y pixel coordinate.
- HIT_DIST, 8, overlap threshold in pixels; collision when both |dx| < HIT_DIST and |dy| < HIT_DIST.
- FRIGHT_FRAMES, 360, frames of frightened mode per power pellet; must be ≥1.
- DYING_FRAMES, 120, frames held in DYING before respawn; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame; the only evaluation point.
- halt  in  1  freeze: while high, frame_tick and power_pellet are ignored and all counters hold.
- pac_x  in  COORD_W  Pac-Man x.
- pac_y  in  COORD_W  Pac-Man y.
- ghost_x  in  4*COORD_W  ghost i x at bits [i*COORD_W +: COORD_W].
- ghost_y  in  4*COORD_W  ghost i y, same packing.
- power_pellet  in  1  one-cycle pulse when a pellet is eaten.
- collide  out  4  event code:
  - 0000 none
  - 0001 Pac-Man killed
  - 0010 ghost eaten
  - other codes never driven.
- ghost_eaten  out  4  bit i set while ghost i is eaten in the current fright window.
- frightened  out  1  high while the fright counter is nonzero.
- dying  out  1  high in the KILL and DYING states.
- respawn  out  1  one-cycle pulse telling position logic to reload start positions.

Behaviour:
- Reset values: all outputs 0, state PLAY, fright_cnt 0, dying_cnt 0, overlap register 0, eval_pending 0.
- Overlap stage (cycle T):
  - On frame_tick && !halt && state==PLAY, register `ovl[i]` = (absdiff(pac_x, gx_i) < HIT_DIST) && (absdiff(pac_y, gy_i) < HIT_DIST).
  - absdiff is unsigned, computed without wrap: larger minus smaller. Set eval_pending.
- Decide stage (cycle T+1, when eval_pending, then clear it):
  - lethal = ovl & ~(frightened ? 4'b1111 : 4'b0000) & ~ghost_eaten.
    - Not frightened: any overlapping ghost, eaten bits are 0.
    - Frightened: none are lethal.
  - edible = frightened ? (ovl & ~ghost_eaten) : 0.
  - If lethal != 0 → state KILL.
  - Else if edible != 0 → set ghost_eaten bit of the lowest-index edible ghost only. Remaining edible ghosts are handled on later frames if still overlapping.
- Output timing: collide is registered and asserted in cycle T+2 for exactly one cycle, then 0000.
  - Kill: 0001. Eat: 0010.
  - At most one event per frame.
  - collide is never held for two consecutive cycles; the lives counter requires single-cycle pulses.
- KILL: one cycle.
  - collide=0001.
  - fright_cnt←0, ghost_eaten←0, dying_cnt←DYING_FRAMES.
  - Go to DYING.
- DYING:
  - Each frame_tick (!halt) decrements dying_cnt.
  - At the tick where dying_cnt==1, go to RESPAWN.
  - Collisions and power_pellet are ignored.
- RESPAWN: one cycle, respawn=1, back to PLAY.
  - The first evaluation uses the next frame_tick after returning to PLAY.
- Fright counter (PLAY only, !halt):
  - power_pellet loads FRIGHT_FRAMES; a reload while frightened keeps ghost_eaten.
  - Each frame_tick decrements a nonzero count.
  - When the count reaches 0, clear ghost_eaten in the same cycle.
  - power_pellet and frame_tick in the same cycle: the load wins.
- Same-cycle interactions: a pellet in the same cycle as a decide stage affects the next frame's decide only. The decide stage uses the frightened value registered before the pellet.
- halt:
  - Rising mid-sequence freezes the state, counters and eval_pending in place.
  - A decide stage already pending completes.
  - KILL and RESPAWN still advance, since they are single-cycle states.
- Reset mid-operation: everything returns to the reset values immediately, with no pulses emitted.

Test Plan:
- Kill: pac (100,100), ghost2 (105,96), not frightened, frame_tick at T.
  - collide=0001 at T+2 for 1 cycle only; dying=1.
  - After 120 ticks: respawn pulse, then dying=0.
- Near miss: pac (100,100), ghost0 (108,100), frame_tick → collide stays 0000. Repeat with x=107 → collide=0001.
- Eat ordering: power_pellet, then ghosts 1 and 3 both overlapping.
  - Tick 1: collide=0010, ghost_eaten=0010.
  - Tick 2: collide=0010, ghost_eaten=1010.
  - Tick 3 (still overlapping): no event.
- Fright expiry: pellet then 360 ticks → frightened falls on tick 360, ghost_eaten→0000.
  - Eaten ghost still overlapping on the next tick → collide=0001.
- Pellet reload: pellet, 200 ticks, pellet again → frightened stays high for 360 more ticks; ghost_eaten is kept.
- halt/reset: assert halt in DYING → dying_cnt frozen across 50 ticks.
  - Assert reset mid-DYING → all outputs 0, no respawn pulse.
